// File: rtl/reg_32_shift_ctrl_if.sv
// Request channel into reg_32_shift_ctrl: valid/ready handshake carrying the
// word to load, the shift direction and the shift length.
interface reg_32_shift_ctrl_if;
  logic        START_VALID;
  logic        START_READY;
  logic [31:0] START_DATA;
  logic        START_DIR;
  logic [5:0]  START_LEN;

  modport master (output START_VALID, START_DATA, START_DIR, START_LEN, input START_READY);
  modport slave  (input START_VALID, START_DATA, START_DIR, START_LEN, output START_READY);
endinterface

// File: rtl/reg_32_shift_ctrl.sv
// Sequencer for a 32-bit shift register: one parallel load, N serial shifts, serial tap capture.
// Optional RX_PARITY output enabled by defining REG32_SHIFT_CTRL_PARITY_EN.
module reg_32_shift_ctrl #(
  parameter logic [1:0] MODO_LOAD  = 2'b10,
  parameter logic [1:0] MODO_SHIFT = 2'b00,
  parameter logic [1:0] MODO_IDLE  = 2'b11,
  parameter logic       FILL_BIT   = 1'b0
) (
  input  logic                CLK,
  input  logic                RESET,
  reg_32_shift_ctrl_if.slave  start,
  input  logic                ABORT,
  input  logic                SER_TAP,
  output logic                ENB,
  output logic [1:0]          MODO,
  output logic                DIR,
  output logic [31:0]         D,
  output logic                S_IN,
  output logic [31:0]         RX_DATA,
  output logic                RX_VALID,
`ifdef REG32_SHIFT_CTRL_PARITY_EN
  output logic                RX_PARITY,
`endif
  output logic                BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_d;
  logic        r_dir;
  logic [31:0] r_rx;
  logic        w_accept;
  logic [5:0]  w_len_eff;

  // Zero and anything above 32 both mean a full-word transfer.
  assign w_len_eff = (start.START_LEN == 6'd0 || start.START_LEN > 6'd32) ? 6'd32 : start.START_LEN;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    ENB          = 1'b0;
    MODO         = MODO_IDLE;
    S_IN         = 1'b0;
    RX_VALID     = 1'b0;
    BUSY         = 1'b1;
    case (r_state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (start.START_VALID) begin
          w_accept     = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        ENB          = 1'b1;
        MODO         = MODO_LOAD;
        w_state_next = ABORT ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        ENB  = 1'b1;
        MODO = MODO_SHIFT;
        S_IN = FILL_BIT;
        if (ABORT) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == 6'd1) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        RX_VALID     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign start.START_READY = ~BUSY;

  // The capture also happens on an aborting shift cycle, so a partial word keeps that bit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt <= 6'd0;
      r_d   <= 32'd0;
      r_dir <= 1'b0;
      r_rx  <= 32'd0;
    end else if (w_accept) begin
      r_cnt <= w_len_eff;
      r_d   <= start.START_DATA;
      r_dir <= start.START_DIR;
      r_rx  <= 32'd0;
    end else if (r_state == S_SHIFT) begin
      r_rx  <= {r_rx[30:0], SER_TAP};
      r_cnt <= r_cnt - 6'd1;
    end
  end

`ifdef REG32_SHIFT_CTRL_PARITY_EN
  logic r_parity;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_parity <= r_parity ^ SER_TAP;
    end
  end

  assign RX_PARITY = r_parity;
`endif

  assign D       = r_d;
  assign DIR     = r_dir;
  assign RX_DATA = r_rx;

endmodule

// File: tb/tb_reg_32_shift_ctrl.sv
// Self-checking bench for reg_32_shift_ctrl: directed table, corner sequences and
// randomized transactions checked against a bit-stream reference of the shift register.
module tb_reg_32_shift_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ABORT;
  logic        SER_TAP;
  logic        ENB;
  logic [1:0]  MODO;
  logic        DIR;
  logic [31:0] D;
  logic        S_IN;
  logic [31:0] RX_DATA;
  logic        RX_VALID;
  logic        BUSY;
`ifdef REG32_SHIFT_CTRL_PARITY_EN
  logic        RX_PARITY;
`endif

  int n_cmp = 0;
  int n_err = 0;

  reg_32_shift_ctrl_if req ();

  reg_32_shift_ctrl dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (req),
    .ABORT    (ABORT),
    .SER_TAP  (SER_TAP),
    .ENB      (ENB),
    .MODO     (MODO),
    .DIR      (DIR),
    .D        (D),
    .S_IN     (S_IN),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
`ifdef REG32_SHIFT_CTRL_PARITY_EN
    .RX_PARITY(RX_PARITY),
`endif
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  // Downstream shift register: loads D on MODO=10, shifts on MODO=00, taps the outgoing end.
  logic [31:0] sr_model = 32'd0;
  logic        use_pat  = 1'b0;
  logic        pat_cur  = 1'b0;

  always @(posedge CLK) begin
    if (ENB) begin
      if (MODO == 2'b10) sr_model <= D;
      else if (MODO == 2'b00) sr_model <= DIR ? {S_IN, sr_model[31:1]} : {sr_model[30:0], S_IN};
    end
  end

  assign SER_TAP = use_pat ? pat_cur : (DIR ? sr_model[0] : sr_model[31]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int eff_len(input logic [5:0] len);
    return (len == 6'd0 || len > 6'd32) ? 32 : int'(len);
  endfunction

  // The j-th bit leaving the register is data[31-j] (DIR=0) or data[j] (DIR=1); it lands at rx[n-1-j].
  function automatic logic [31:0] ref_rx(input logic [31:0] data, input logic dir, input int n);
    logic [31:0] r;
    r = 32'd0;
    for (int j = 0; j < n; j++) r[n-1-j] = dir ? data[j] : data[31-j];
    return r;
  endfunction

  task automatic txn(input string name, input logic [31:0] data, input logic dir,
                     input logic [5:0] len, input logic [31:0] exp_rx, input bit pat_mode,
                     input logic [31:0] pat, input int abort_at, input bit noisy);
    int n;
    int waited;
    n = eff_len(len);
    waited = 0;
    @(negedge CLK);
    while (!req.START_READY && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    chk({name, " ready"}, 32'(req.START_READY), 32'd1);
    use_pat = pat_mode;
    req.START_VALID = 1'b1;
    req.START_DATA  = data;
    req.START_DIR   = dir;
    req.START_LEN   = len;
    @(negedge CLK);
    req.START_VALID = 1'b0;
    chk({name, " load ctl"}, {26'd0, ENB, MODO, DIR, BUSY, req.START_READY},
        {26'd0, 1'b1, 2'b10, dir, 1'b1, 1'b0});
    chk({name, " load D"}, D, data);
    for (int k = 1; k <= n; k++) begin
      @(negedge CLK);
      if (pat_mode) pat_cur = pat[n-k];
      chk({name, " shift ctl"}, {27'd0, ENB, MODO, S_IN, RX_VALID}, {27'd0, 1'b1, 2'b00, 1'b0, 1'b0});
      chk({name, " shift D"}, D, data);
      if (noisy) begin
        req.START_VALID = (k < n);
        req.START_DATA  = ~data;
        req.START_DIR   = ~dir;
        req.START_LEN   = 6'd1;
      end
      if (k == abort_at) begin
        ABORT = 1'b1;
        break;
      end
    end
    req.START_VALID = 1'b0;
    @(negedge CLK);
    if (abort_at != 0) begin
      ABORT = 1'b0;
      chk({name, " abort ctl"}, {28'd0, ENB, RX_VALID, req.START_READY, BUSY}, {28'd0, 1'b0, 1'b0, 1'b1, 1'b0});
      chk({name, " abort rx"}, RX_DATA, exp_rx);
    end else begin
      chk({name, " done ctl"}, {28'd0, ENB, MODO, RX_VALID}, {28'd0, 1'b0, 2'b11, 1'b1});
      chk({name, " done busy"}, 32'(BUSY), 32'd1);
      chk({name, " rx"}, RX_DATA, exp_rx);
    end
`ifdef REG32_SHIFT_CTRL_PARITY_EN
    chk({name, " parity"}, 32'(RX_PARITY), 32'(^exp_rx));
`endif
    @(negedge CLK);
    chk({name, " post ctl"}, {28'd0, RX_VALID, BUSY, req.START_READY, DIR}, {28'd0, 1'b0, 1'b0, 1'b1, dir});
    chk({name, " post hold"}, RX_DATA ^ D, exp_rx ^ data);
    use_pat = 1'b0;
    $display("txn %s data=%h dir=%0d len=%0d abort_at=%0d rx=%h", name, data, dir, len, abort_at, RX_DATA);
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic        dir;
    logic [5:0]  len;
    logic [31:0] exp_rx;
  } vec_t;

  vec_t        tbl [9];
  logic [31:0] r_data;
  logic        r_dir;
  logic [5:0]  r_len;
  int          r_abort;
  int          ready_cyc[$];
  int          flow_err;

  initial begin
    tbl[0] = '{32'hA5A5_0F0F, 1'b0, 6'd0,  32'hA5A5_0F0F};
    tbl[1] = '{32'hA5A5_0F0F, 1'b1, 6'd0,  32'hF0F0_A5A5};
    tbl[2] = '{32'h1234_5678, 1'b0, 6'd4,  32'h0000_0001};
    tbl[3] = '{32'h1234_5678, 1'b0, 6'd40, 32'h1234_5678};
    tbl[4] = '{32'h8000_0001, 1'b1, 6'd1,  32'h0000_0001};
    tbl[5] = '{32'hDEAD_BEEF, 1'b0, 6'd16, 32'h0000_DEAD};
    tbl[6] = '{32'h0000_00F0, 1'b1, 6'd8,  32'h0000_000F};
    tbl[7] = '{32'h7FFF_FFFF, 1'b0, 6'd1,  32'h0000_0000};
    tbl[8] = '{32'hFFFF_FFFF, 1'b0, 6'd33, 32'hFFFF_FFFF};

    RESET = 1'b1;
    ABORT = 1'b0;
    req.START_VALID = 1'b0;
    req.START_DATA  = 32'd0;
    req.START_DIR   = 1'b0;
    req.START_LEN   = 6'd0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    chk("reset ctl", {24'd0, req.START_READY, ENB, MODO, RX_VALID, BUSY, DIR, S_IN},
        {24'd0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("reset rx", RX_DATA, 32'd0);
    chk("reset D", D, 32'd0);
`ifdef REG32_SHIFT_CTRL_PARITY_EN
    chk("reset parity", 32'(RX_PARITY), 32'd0);
`endif

    for (int i = 0; i < 9; i++)
      txn($sformatf("tbl%0d", i), tbl[i].data, tbl[i].dir, tbl[i].len, tbl[i].exp_rx, 1'b0, 32'd0, 0, (i % 3) == 2);

    txn("short", 32'h0000_0000, 1'b1, 6'd4, 32'h0000_000B, 1'b1, 32'h0000_000B, 0, 1'b0);
    txn("abort5", 32'h1357_9BDF, 1'b0, 6'd16, 32'h0000_0016, 1'b1, 32'h0000_B3C5, 5, 1'b0);
    txn("abort_last", 32'h0, 1'b0, 6'd4, 32'h0000_000B, 1'b1, 32'h0000_000B, 4, 1'b0);
`ifdef REG32_SHIFT_CTRL_PARITY_EN
    txn("par_even", 32'h0, 1'b0, 6'd8, 32'h0000_00D1, 1'b1, 32'h0000_00D1, 0, 1'b0);
    chk("par_even value", 32'(RX_PARITY), 32'd0);
    txn("par_odd", 32'h0, 1'b0, 6'd8, 32'h0000_00D3, 1'b1, 32'h0000_00D3, 0, 1'b0);
    chk("par_odd value", 32'(RX_PARITY), 32'd1);
`endif

    // Reset in the middle of a shift sequence.
    @(negedge CLK);
    req.START_VALID = 1'b1;
    req.START_DATA  = 32'hCAFE_F00D;
    req.START_DIR   = 1'b1;
    req.START_LEN   = 6'd10;
    @(negedge CLK);
    req.START_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("midreset ctl", {25'd0, ENB, MODO, RX_VALID, BUSY, req.START_READY, DIR},
        {25'd0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0});
    chk("midreset D", D, 32'd0);
    chk("midreset rx", RX_DATA, 32'd0);
    @(negedge CLK);
    chk("midreset no valid", 32'(RX_VALID), 32'd0);
    $display("txn midreset data=cafef00d len=10 reset after 2 shifts");

    // Back-pressure: a request held high is taken once every N+3 = 5 cycles.
    req.START_VALID = 1'b1;
    req.START_DATA  = 32'h0F0F_3C3C;
    req.START_DIR   = 1'b0;
    req.START_LEN   = 6'd2;
    flow_err = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (req.START_READY === BUSY) flow_err++;
      if (req.START_READY) ready_cyc.push_back(c);
    end
    req.START_VALID = 1'b0;
    chk("bp ready_vs_busy", 32'(flow_err), 32'd0);
    chk("bp accept count", 32'(ready_cyc.size()), 32'd8);
    for (int i = 1; i < ready_cyc.size(); i++)
      chk($sformatf("bp spacing%0d", i), 32'(ready_cyc[i] - ready_cyc[i-1]), 32'd5);
    $display("txn backpressure len=2 windows=%0d", ready_cyc.size());
    repeat (6) @(negedge CLK);

    for (int i = 0; i < 24; i++) begin
      r_data  = $urandom;
      r_dir   = 1'($urandom_range(0, 1));
      r_len   = 6'($urandom_range(0, 63));
      r_abort = ((i % 5) == 3) ? $urandom_range(1, eff_len(r_len)) : 0;
      txn($sformatf("rnd%0d", i), r_data, r_dir, r_len,
          ref_rx(r_data, r_dir, (r_abort != 0) ? r_abort : eff_len(r_len)),
          1'b0, 32'd0, r_abort, (i % 4) == 1);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_32_shift_ctrl.md
Name: reg_32_shift_ctrl

Overview:
- Sequencing controller that sits directly upstream of the 32-bit shift register.
- Accepts a word plus a shift request over a valid/ready handshake, then drives the register's ENB/MODO/DIR/D/S_IN lines:
  - one parallel-load cycle;
  - N serial-shift cycles.
- Captures the register's serial tap (one S_OUT bit) into a receive word and pulses RX_VALID when the transaction completes.

Parameters:
- MODO_LOAD, 2'b10, MODO encoding driven during the parallel-load cycle.
- MODO_SHIFT, 2'b00, MODO encoding driven during shift cycles.
- MODO_IDLE, 2'b11, MODO encoding driven when not loading or shifting.
- FILL_BIT, 1'b0, value driven on S_IN during shift cycles.

Ports:
- CLK  in  1  clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- START_VALID  in  1  request valid
- START_READY  out  1  controller can accept a request
- START_DATA  in  32  word to parallel-load
- START_DIR  in  1  shift direction for this transaction, forwarded to DIR
- START_LEN  in  6  shift count; 1..32 legal, 0 means 32, values >32 saturate to 32
- ABORT  in  1  terminate the current transaction
- SER_TAP  in  1  serial bit returned from the register's S_OUT
- ENB  out  1  register enable
- MODO  out  2  register mode
- DIR  out  1  register direction
- D  out  32  register parallel data
- S_IN  out  1  register serial input
- RX_DATA  out  32  captured serial bits
- RX_VALID  out  1  one-cycle pulse: RX_DATA is complete
- BUSY  out  1  transaction in progress

Behaviour:
- Clock and reset:
  - Single clock CLK.
  - RESET is synchronous and active-high; it has priority over every other input.
- Reset values:
  - State IDLE; START_READY=1; ENB=0; MODO=MODO_IDLE; DIR=0; D=0; S_IN=0.
  - RX_DATA=0; RX_VALID=0; BUSY=0; shift counter=0.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - START_READY=1, ENB=0, MODO=MODO_IDLE.
  - On START_VALID&START_READY: latch START_DATA→D, START_DIR→DIR, and effective length N→counter; clear RX_DATA; go to LOAD.
- LOAD (exactly 1 cycle):
  - ENB=1, MODO=MODO_LOAD, D=latched word.
  - Go to SHIFT.
- SHIFT (exactly N cycles):
  - ENB=1, MODO=MODO_SHIFT, S_IN=FILL_BIT.
  - Each cycle: RX_DATA <= {RX_DATA[30:0], SER_TAP}; counter decrements.
  - Leave to DONE on the edge where counter==1.
  - Result: the first sampled bit ends at RX_DATA[N-1]; bits above N-1 are 0.
- DONE (1 cycle):
  - ENB=0, MODO=MODO_IDLE, RX_VALID=1.
  - Go to IDLE.
- Outputs outside LOAD/SHIFT:
  - BUSY=1 in LOAD, SHIFT and DONE; START_READY = !BUSY.
  - D and DIR hold their last latched values after the transaction (not cleared).
- Latency:
  - Request accepted at edge t → LOAD during cycle t+1 → SHIFT cycles t+2..t+1+N → RX_VALID during cycle t+2+N.
  - Next request can be accepted at edge t+3+N.
  - Throughput: one transaction per N+3 cycles.
- ABORT:
  - ABORT in LOAD or SHIFT: go to IDLE next edge; ENB=0 from that edge; RX_VALID is not pulsed; RX_DATA keeps its partial contents.
  - ABORT in IDLE or DONE is ignored; DONE still pulses RX_VALID.
- Simultaneous events:
  - START_VALID while BUSY: not accepted, no side effects; the requester must hold the request.
  - RESET during any state: IDLE next edge, all outputs at reset values, no RX_VALID.
- Length rules:
  - N=1: one SHIFT cycle; RX_DATA[0]=captured bit.
  - N=32: full word; RX_DATA[31] is the first captured bit.

Optional Feature:
- Macro: REG32_SHIFT_CTRL_PARITY_EN.
- When defined:
  - Adds output RX_PARITY (1 bit): XOR of all bits captured in the transaction.
  - Valid with RX_VALID; holds until the next accepted request clears it.
  - Reset value 0.
  - An aborted transaction leaves the parity of the partial capture.
- When undefined: port absent; no parity logic.

Test Plan:
- Reset then idle:
  - Stimulus: RESET high 2 cycles, release.
  - Required: START_READY=1, ENB=0, MODO=2'b11, RX_VALID=0, RX_DATA=0.
- Full 32-bit shift:
  - Stimulus: DATA=32'hA5A5_0F0F, DIR=0, LEN=0; SER_TAP driven from a reference model of the register.
  - Required: one LOAD cycle with D=32'hA5A5_0F0F and MODO=2'b10; 32 SHIFT cycles; RX_VALID exactly 34 cycles after accept; RX_DATA equals the model's shifted-out stream.
- Short shift:
  - Stimulus: LEN=4, DIR=1, SER_TAP pattern 1,0,1,1.
  - Required: 4 SHIFT cycles; RX_DATA=32'h0000_000B; BUSY low 7 cycles after accept.
- Abort:
  - Stimulus: LEN=16, ABORT in 5th SHIFT cycle.
  - Required: ENB=0 next cycle; no RX_VALID; START_READY=1; RX_DATA holds 5 captured bits.
- Back-pressure:
  - Stimulus: START_VALID held high continuously with LEN=2.
  - Required: accepts exactly every 5 cycles; no request accepted while BUSY=1.
- Parity (macro on):
  - Stimulus: LEN=8, SER_TAP=8'b1101_0001.
  - Required: RX_PARITY=0 with RX_VALID; repeat with 8'b1101_0011 → RX_PARITY=1.
